// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller sharing one 1-bit full
// adder across WIDTH-bit operands, LSB first, with a registered carry.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start           request, sampled only while idle
//   a, b, cin, sub  operands / carry-in / subtract select, captured on accept
//   busy            high while adding and in the completion cycle
//   done            one-cycle pulse, results valid
//   sum, cout, ovf  registered result, carry out of MSB, signed overflow

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa_sr, opb_sr, res_sr;
  logic             sub_q, carry_q, cmsb_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_carry;

  // Subtraction is A + ~B + 1: invert B one bit at a time as it shifts out.
  fa u_fa (
    .a  (opa_sr[0]),
    .b  (opb_sr[0] ^ sub_q),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opa_sr  <= '0;
      opb_sr  <= '0;
      res_sr  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa_sr  <= a;
            opb_sr  <= b;
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
            cnt     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
          carry_q <= fa_carry;
          opa_sr  <= opa_sr >> 1;
          opb_sr  <= opb_sr >> 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry_q here is the carry into the MSB; with the MSB carry-out
            // it gives two's-complement overflow.
            cmsb_q <= carry_q;
            sum    <= {fa_sum, res_sr[WIDTH-1:1]};
            cout   <= fa_carry;
            ovf    <= carry_q ^ fa_carry;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modulo arithmetic on the whole word.
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, tb_,
                                         input logic tc, ts);
    logic [W-1:0] bb, s;
    logic [W:0]   r;
    logic         c, o;
    bb = ts ? ~tb_ : tb_;
    c  = ts ? 1'b1 : tc;
    r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c};
    s  = r[W-1:0];
    o  = (ta[W-1] == bb[W-1]) && (s[W-1] != ta[W-1]);
    return {o, r[W], s};
  endfunction

  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0, prev_ovf = 1'b0;

  task automatic do_op(input logic [W-1:0] ta, tb_, input logic tc, ts, input string tag);
    logic [W+1:0] e;
    int lat;
    e = model(ta, tb_, tc, ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, " busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (lat == 4) chk({tag, " held"}, {prev_ovf, prev_cout, sum}, {ovf, cout, prev_sum});
    end
    chk({tag, " lat"}, lat, W);
    chk({tag, " sum"}, sum, e[W-1:0]);
    chk({tag, " cout"}, cout, e[W]);
    chk({tag, " ovf"}, ovf, e[W+1]);
    prev_sum = sum; prev_cout = cout; prev_ovf = ovf;
    @(posedge clk); #1;
    chk({tag, " pulse"}, {busy, done}, 0);
  endtask

  initial begin
    logic [W-1:0] qa[$], qb[$];
    logic         qc[$], qs[$];
    logic [W+1:0] e;
    int ndone, nd;

    // Reset asserted from time zero; release between edges.
    #12;
    chk("rst busy", busy, 0);
    chk("rst out", {done, cout, ovf, sum}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle out", {busy, done, cout, ovf, sum}, 0);

    do_op(8'h3C, 8'h5A, 1'b0, 1'b0, "ovf_add");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, "chain1");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "chain2");
    do_op(8'h05, 8'h07, 1'b0, 1'b1, "sub1");
    do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub2");
    for (int i = 0; i < 10; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");

    // Reset between edges while idle with nonzero outputs.
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("async rst", {busy, done, cout, ovf, sum}, 0);
    @(negedge clk); rst = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

    // start held high with churning operands: accepts on edges 0,10,20,30.
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k >= 9 && (k - 9) % 10 == 0 && k <= 39) begin
        chk("b2b done", done, 1);
        if (qa.size() > 0) begin
          e = model(qa.pop_front(), qb.pop_front(), qc.pop_front(), qs.pop_front());
          chk("b2b res", {ovf, cout, sum}, e);
        end
      end else begin
        chk("b2b nodone", done, 0);
      end
      if (done) ndone++;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      start = (k < 40);
      if (k < 40 && k % 10 == 0) begin
        qa.push_back(a); qb.push_back(b); qc.push_back(cin); qs.push_back(sub);
      end
    end
    chk("b2b count", ndone, 4);
    start = 1'b0;
    prev_sum = sum; prev_cout = cout; prev_ovf = ovf;

    // Reset during the 4th ADD cycle aborts the op.
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("mid rst out", {busy, done, cout, ovf, sum}, 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (12) begin @(negedge clk); if (done) nd++; end
    chk("mid rst nodone", nd, 0);
    chk("mid rst held", {cout, ovf, sum}, 0);
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    do_op(8'h10, 8'h22, 1'b1, 1'b0, "recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that time-shares one 1-bit full adder (`fa`) across WIDTH-bit operands. It processes one bit per clock, LSB first, with a registered carry between bits. It sits between a requester issuing start/operand pulses and the shared `fa` datapath. It also sequences operand shifting, carry recirculation, result assembly and a completion handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; used when sub=0, captured on the accepting edge.
- sub  input  1  1 = A − B (B inverted, carry-in forced 1, cin ignored); captured on the accepting edge.
- busy  output  1  high in ADD and DONE states.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  registered result; held until the next DONE.
- cout  output  1  carry out of the MSB; for sub=1, 1 means no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- One `fa` instance only. Its inputs are opA_sr[0], (opB_sr[0] ^ sub_q) and carry_q.
- States: IDLE, ADD, DONE.
- **IDLE**
  - busy=0, done=0.
  - If start=1 at a rising edge:
    - opA_sr ← a, opB_sr ← b, sub_q ← sub.
    - carry_q ← (sub ? 1 : cin), bit counter ← 0, go to ADD.
- **ADD**, each edge:
  - res_sr ← {fa.sum, res_sr[WIDTH-1:1]}.
  - carry_q ← fa.carry.
  - opA_sr and opB_sr shift right by 1.
  - counter increments.
  - When counter = WIDTH−1, the current carry_q (carry into the MSB) is also latched into cmsb_q.
  - On that same edge the state moves to DONE, and these load together:
    - sum ← {fa.sum, res_sr[WIDTH-1:1]}
    - cout ← fa.carry
    - ovf ← cmsb_q_next ^ fa.carry
- **DONE**
  - done=1, busy=1, for exactly one cycle.
  - Unconditionally returns to IDLE.
- start while busy=1 is ignored. It is not queued.
- a/b/cin/sub changes after acceptance do not affect the operation in flight.
- sum/cout/ovf change only on the edge entering DONE, or on reset. They never show partial results.
- Bit counter width is $clog2(WIDTH). Arithmetic is modulo 2^WIDTH.

## Timing
- Reset (async, rst=1, effective immediately without a clock edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - All internal registers are cleared.
- Reset asserted mid-ADD or in DONE aborts the operation. No done pulse is produced. Outputs clear immediately.
- Edge numbering: start is accepted at edge E0.
  - Bits 0..WIDTH−1 are computed at edges E1..E_WIDTH.
  - done=1 and results are valid from E_WIDTH until E_WIDTH+1.
- Latency: WIDTH cycles from the accepting edge to done high. Occupancy is WIDTH+1 cycles.
- Earliest next acceptance is edge E_WIDTH+2 (start held high continuously gives back-to-back operations at this rate).
- busy rises after E0 and falls after E_WIDTH+1.

## Test plan
- **Reset:** assert rst between clock edges.
  - Outputs are 0 immediately; busy=0.
  - Release rst; with no start, the outputs stay 0.
- **Add with signed overflow:** WIDTH=8, a=8'h3C, b=8'h5A, cin=0, sub=0.
  - done is high exactly 8 cycles after the accepting edge, for 1 cycle.
  - sum=8'h96, cout=0, ovf=1.
- **Carry chains:**
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, ovf=0.
- **Subtract** (sub=1; cin=1 is driven in the second case and must be ignored):
  - a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0.
  - a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- **Protocol:**
  - Hold start=1 continuously and change a/b every cycle during busy. Only operands present at each IDLE-state acceptance are used.
  - Acceptances are 10 cycles apart. The done pulse count equals the acceptance count.
- **Mid-op reset and recovery:**
  - Assert rst at the 4th ADD cycle of a=8'h3C, b=8'h5A. No done pulse; outputs are 0.
  - Next op a=8'h10, b=8'h22, cin=1 → sum=8'h33, cout=0, ovf=0.
